// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D, RESP)
//   owner_e : which requester a grant goes to
//   pick_owner : data-over-fetch priority with a fetch starvation bound
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned TMO_W    = 8;

  // Data wins unless fetch is waiting and has already been passed over
  // starve_max times in a row.
  function automatic owner_e pick_owner(
    input logic                if_req,
    input logic                d_req,
    input logic [STARVE_W-1:0] starve_cnt,
    input logic [STARVE_W-1:0] starve_max
  );
    owner_e own;
    own = OWN_NONE;
    if (d_req && (!if_req || (starve_cnt < starve_max))) begin
      own = OWN_D;
    end else if (if_req) begin
      own = OWN_I;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Busy-state timeout counter for mem_port_arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   i_clr     : synchronous clear (held while not in a busy state)
//   i_en      : count enable (one increment per busy cycle)
//   o_tmo_hit : high during the TIMEOUT-th consecutive busy cycle
module mem_arb_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tmo_hit
);

  localparam logic [TMO_W-1:0] LP_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  // r_cnt holds the number of busy cycles already completed, so the hit
  // lands on the TIMEOUT-th busy cycle and mem_req is high exactly TIMEOUT
  // cycles on an unanswered access.
  assign o_tmo_hit = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch port and
// the load/store data port, one req/ready transaction at a time.
//   clk, rst                       : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request (held until if_valid)
//   if_rdata/if_valid              : fetched word, one-cycle completion pulse
//   lw_en/sw_en/d_addr/d_wdata     : load/store request (held until d_valid)
//   d_rdata/d_valid                : load data, one-cycle completion pulse
//   stall                          : pipeline hold while a request waits
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ready            : memory response
//   err                            : sticky error (timeout or lw+sw together)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              lw_en,
  input  logic              sw_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_MAX);

  state_e              r_state;
  state_e              w_state_nxt;
  owner_e              w_own;
  logic                w_d_req;
  logic                w_busy;
  logic                w_tmo_hit;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_if_valid;
  logic                r_d_valid;
  logic                r_err;

  assign w_d_req = lw_en | sw_en;
  assign w_own   = pick_owner(if_req, w_d_req, r_starve_cnt, LP_STARVE_MAX);
  assign w_busy  = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);

  mem_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_busy),
    .i_en     (w_busy),
    .o_tmo_hit(w_tmo_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_own == OWN_D) begin
          w_state_nxt = S_BUSY_D;
        end else if (w_own == OWN_I) begin
          w_state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mem_ready || w_tmo_hit) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant capture, response capture and the starvation counter. The valid
  // pulses default low so each is high for exactly the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_own == OWN_D) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= sw_en;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (lw_en && sw_en) begin
              r_err <= 1'b1;
            end
            if (!if_req) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt < LP_STARVE_MAX) begin
              r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
          end else if (w_own == OWN_I) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_starve_cnt <= '0;
          end
        end
        S_BUSY_I: begin
          if (mem_ready) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_valid <= 1'b1;
          end else if (w_tmo_hit) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= '0;
            r_if_valid <= 1'b1;
            r_err      <= 1'b1;
          end
        end
        S_BUSY_D: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_d_valid <= 1'b1;
            if (!r_mem_we) begin
              r_d_rdata <= mem_rdata;
            end
          end else if (w_tmo_hit) begin
            r_mem_req <= 1'b0;
            r_d_rdata <= '0;
            r_d_valid <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall     = (if_req | lw_en | sw_en) & (r_state != S_RESP);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned SMAX = 4;
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        lw_en;
  logic        sw_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(SMAX),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .lw_en    (lw_en),
    .sw_en    (sw_en),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_valid  (d_valid),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural memory: contents plus a responder with per-access latency.
  logic [31:0] mem_model [logic [31:0]];
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 1;
  int unsigned busy_cnt  = 0;
  int unsigned cur_lat   = 1;
  bit          mem_stuck = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called once per cycle after sampling; decides mem_ready for the next edge.
  task automatic mem_respond();
    if (mem_req) begin
      busy_cnt++;
      if (busy_cnt == 1) cur_lat = $urandom_range(lat_max, lat_min);
      if (!mem_stuck && busy_cnt >= cur_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read(mem_addr);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom();
      end
    end else begin
      busy_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; if_req = 1'b0; lw_en = 1'b0; sw_en = 1'b0;
    mem_ready = 1'b0; busy_cnt = 0; mem_stuck = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; lw_en = 1'b0; sw_en = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #3 rst = 1'b0;
    #4;
    n_checks++;
    if ({if_rdata, d_rdata, if_valid, d_valid, mem_req, mem_we, mem_addr, mem_wdata, err, stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got if_rdata=%h d_rdata=%h v=%b%b mem_req=%b we=%b addr=%h wdata=%h err=%b stall=%b, required all 0",
               if_rdata, d_rdata, if_valid, d_valid, mem_req, mem_we, mem_addr, mem_wdata, err, stall);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int req_cyc = 0;
    int pulses  = 0;
    lat_min = 2; lat_max = 2;
    mem_model[32'h100] = 32'h0000_0013;
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_req) begin
        req_cyc++;
        n_checks++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL fetch_mem: got addr=%h we=%b, required 00000100 0", mem_addr, mem_we);
        end
        n_checks++;
        if (stall !== 1'b1) begin
          n_fail++; $display("FAIL fetch_stall_busy: got %b, required 1", stall);
        end
      end
      n_checks++;
      if (d_valid !== 1'b0) begin
        n_fail++; $display("FAIL fetch_no_dvalid: got %b, required 0", d_valid);
      end
      if (if_valid) begin
        pulses++;
        n_checks++;
        if (if_rdata !== 32'h13) begin
          n_fail++; $display("FAIL fetch_rdata: got %h, required 00000013", if_rdata);
        end
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++; $display("FAIL fetch_stall_resp: got %b, required 0", stall);
        end
        if_req = 1'b0;
      end
      mem_respond();
    end
    n_checks++;
    if (req_cyc != 2) begin
      n_fail++; $display("FAIL fetch_req_cycles: got %0d, required 2", req_cyc);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL fetch_pulses: got %0d, required 1", pulses);
    end
  endtask

  task automatic test_store();
    int pulses = 0;
    lat_min = 1; lat_max = 1;
    d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; sw_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mem_req) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h20) begin
          n_fail++; $display("FAIL store_mem: got we=%b wdata=%h addr=%h, required 1 deadbeef 00000020", mem_we, mem_wdata, mem_addr);
        end
      end
      if (d_valid) begin
        pulses++;
        n_checks++;
        if (d_rdata !== 32'h0) begin
          n_fail++; $display("FAIL store_rdata_kept: got %h, required 00000000", d_rdata);
        end
        sw_en = 1'b0;
      end
      mem_respond();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL store_pulses: got %0d, required 1", pulses);
    end
    n_checks++;
    if (mem_read(32'h20) !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_written: got %h, required deadbeef", mem_read(32'h20));
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL store_err: got %b, required 0", err);
    end
  endtask

  task automatic test_contention();
    int  g = 0;
    bit  prev_req = 1'b0;
    bit  got_i;
    bit  exp_i;
    bit  done = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 3;
    if_addr = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
    d_addr  = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
    if_req = 1'b1; lw_en = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (mem_req && !prev_req) begin
        got_i = (mem_addr == if_addr);
        exp_i = ((g % (SMAX + 1)) == SMAX);
        n_checks++;
        if (got_i !== exp_i) begin
          n_fail++; $display("FAIL contention_grant%0d: got fetch=%b, required fetch=%b", g, got_i, exp_i);
        end
        g++;
      end
      prev_req = mem_req;
      if (if_valid) begin
        n_checks++;
        if (if_rdata !== mem_read(if_addr)) begin
          n_fail++; $display("FAIL contention_if_rdata: got %h, required %h", if_rdata, mem_read(if_addr));
        end
        if_addr = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      end
      if (d_valid) begin
        n_checks++;
        if (d_rdata !== mem_read(d_addr)) begin
          n_fail++; $display("FAIL contention_d_rdata: got %h, required %h", d_rdata, mem_read(d_addr));
        end
        d_addr = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
      end
      if ((if_valid || d_valid) && g >= 15) begin
        if_req = 1'b0; lw_en = 1'b0; done = 1'b1;
      end
      mem_respond();
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL contention_budget: got %0d grants, required 15 within budget", g);
    end
    tick(); mem_respond(); tick(); mem_respond();
  endtask

  // Random traffic against a cycle model: phase 0 idle, 1 access
  // outstanding at the memory, 2 response cycle.
  task automatic test_random();
    int          phase = 0;
    int          own   = 0;
    int unsigned cons  = 0;
    bit          own_st = 1'b0;
    logic [31:0] exp_if  = '0;
    logic [31:0] exp_d   = '0;
    logic [31:0] exp_a;
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int c = 0; c < 400; c++) begin
      tick();
      case (phase)
        0: begin
          if ((lw_en | sw_en) && (!if_req || cons < SMAX)) begin
            own = 2; own_st = sw_en; phase = 1;
            cons = if_req ? ((cons < SMAX) ? cons + 1 : cons) : 0;
          end else if (if_req) begin
            own = 1; cons = 0; phase = 1;
          end
        end
        1: if (mem_ready) begin
          phase = 2;
          if (own == 1) exp_if = mem_read(if_addr);
          else if (!own_st) exp_d = mem_read(d_addr);
        end
        default: phase = 0;
      endcase
      n_checks++;
      if (mem_req !== (phase == 1)) begin
        n_fail++; $display("FAIL rnd_mem_req c%0d: got %b, required %b", c, mem_req, phase == 1);
      end
      if (phase == 1) begin
        exp_a = (own == 1) ? if_addr : d_addr;
        n_checks++;
        if (mem_addr !== exp_a || mem_we !== (own == 2 && own_st)) begin
          n_fail++; $display("FAIL rnd_grant c%0d: got addr=%h we=%b, required addr=%h we=%b", c, mem_addr, mem_we, exp_a, own == 2 && own_st);
        end
        if (own == 2 && own_st) begin
          n_checks++;
          if (mem_wdata !== d_wdata) begin
            n_fail++; $display("FAIL rnd_wdata c%0d: got %h, required %h", c, mem_wdata, d_wdata);
          end
        end
      end
      n_checks++;
      if (if_valid !== (phase == 2 && own == 1) || d_valid !== (phase == 2 && own == 2)) begin
        n_fail++; $display("FAIL rnd_valid c%0d: got if=%b d=%b, required if=%b d=%b", c, if_valid, d_valid, phase == 2 && own == 1, phase == 2 && own == 2);
      end
      n_checks++;
      if (if_rdata !== exp_if || d_rdata !== exp_d) begin
        n_fail++; $display("FAIL rnd_rdata c%0d: got if=%h d=%h, required if=%h d=%h", c, if_rdata, d_rdata, exp_if, exp_d);
      end
      n_checks++;
      if (stall !== ((if_req | lw_en | sw_en) && phase != 2)) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b, required %b", c, stall, (if_req | lw_en | sw_en) && phase != 2);
      end
      if (phase == 2) begin
        if (own == 1) if_req = 1'b0;
        else begin lw_en = 1'b0; sw_en = 1'b0; end
      end
      if (c < 300) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!(lw_en | sw_en) && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) sw_en = 1'b1; else lw_en = 1'b1;
          d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom();
        end
      end
      mem_respond();
    end
    n_checks++;
    if ((if_req | lw_en | sw_en) || phase != 0) begin
      n_fail++; $display("FAIL rnd_drain: got pending=%b phase=%0d, required idle", if_req | lw_en | sw_en, phase);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL rnd_err: got %b, required 0", err);
    end
  endtask

  task automatic test_illegal();
    int          pulses = 0;
    logic [31:0] wd;
    lat_min = 1; lat_max = 1;
    wd = $urandom();
    d_addr = 32'h30; d_wdata = wd; lw_en = 1'b1; sw_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mem_req) begin
        n_checks++;
        if (mem_we !== 1'b1) begin
          n_fail++; $display("FAIL illegal_we: got %b, required 1", mem_we);
        end
      end
      if (d_valid) begin
        pulses++; lw_en = 1'b0; sw_en = 1'b0;
      end
      mem_respond();
    end
    n_checks++;
    if (pulses != 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_err: got pulses=%0d err=%b, required 1 1", pulses, err);
    end
    n_checks++;
    if (mem_read(32'h30) !== wd) begin
      n_fail++; $display("FAIL illegal_store: got %h, required %h", mem_read(32'h30), wd);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int grants = 0;
    bit prev_req = 1'b0;
    mem_stuck = 1'b1;
    d_addr = 32'h60; lw_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); mem_respond();
    end
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy: got mem_req=%b, required 1", mem_req);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if_rdata, d_rdata, if_valid, d_valid, mem_req, mem_we, mem_addr, mem_wdata, err} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got mem_req=%b we=%b addr=%h wdata=%h err=%b v=%b%b, required all 0",
                         mem_req, mem_we, mem_addr, mem_wdata, err, if_valid, d_valid);
    end
    lw_en = 1'b0; if_req = 1'b1; if_addr = 32'h200; mem_stuck = 1'b0;
    tick(); mem_respond();
    rst = 1'b1;
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (d_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_no_dvalid: got %b, required 0", d_valid);
      end
      if (mem_req && !prev_req) begin
        grants++;
        n_checks++;
        if (mem_addr !== 32'h200 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_grant: got addr=%h we=%b, required 00000200 0", mem_addr, mem_we);
        end
      end
      prev_req = mem_req;
      if (if_valid) begin
        pulses++;
        n_checks++;
        if (if_rdata !== mem_read(32'h200)) begin
          n_fail++; $display("FAIL rstmid_rdata: got %h, required %h", if_rdata, mem_read(32'h200));
        end
        if_req = 1'b0;
      end
      mem_respond();
    end
    n_checks++;
    if (pulses != 1 || grants != 1) begin
      n_fail++; $display("FAIL rstmid_count: got pulses=%0d grants=%0d, required 1 1", pulses, grants);
    end
  endtask

  task automatic test_timeout();
    int pulses  = 0;
    int req_cyc = 0;
    lat_min = 2; lat_max = 2;
    d_addr = 32'h44; lw_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (d_valid) begin
        pulses++; lw_en = 1'b0;
        n_checks++;
        if (d_rdata !== mem_read(32'h44)) begin
          n_fail++; $display("FAIL tmo_preload: got %h, required %h", d_rdata, mem_read(32'h44));
        end
      end
      mem_respond();
    end
    n_checks++;
    if (pulses != 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pre_state: got pulses=%0d err=%b, required 1 0", pulses, err);
    end
    pulses = 0;
    mem_stuck = 1'b1;
    d_addr = 32'h48; lw_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req) req_cyc++;
      if (d_valid) begin
        pulses++; lw_en = 1'b0;
        n_checks++;
        if (d_rdata !== 32'h0 || err !== 1'b1) begin
          n_fail++; $display("FAIL tmo_resp: got d_rdata=%h err=%b, required 00000000 1", d_rdata, err);
        end
      end
      mem_respond();
    end
    n_checks++;
    if (req_cyc != TMO || pulses != 1) begin
      n_fail++; $display("FAIL tmo_cycles: got req_cycles=%0d pulses=%0d, required %0d 1", req_cyc, pulses, TMO);
    end
    n_checks++;
    if (err !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL tmo_sticky: got err=%b mem_req=%b, required 1 0", err, mem_req);
    end
    mem_stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_random();
    test_illegal();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
